phy_reset_transmitter: RTL and testbench

Physical-layer transmitter for USB PD Hard Reset and Cable Reset signalling. It sits directly downstream of the protocol-layer reset state machine and consumes the TRANSMIT register that machine writes. On a start request it serializes a 64-bit preamble and then the 4-K-code reset ordered set onto the CC line. It reports completion or failure back to the protocol layer as single-cycle pulses.

---
 rtl/phy_reset_transmitter_if.sv | 22 ++
 rtl/phy_reset_transmitter.sv | 135 +++++++++++++
 tb/tb_phy_reset_transmitter.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/phy_reset_transmitter_if.sv
// Protocol-layer <-> reset PHY transmitter signal bundle.
// master = protocol layer, slave = PHY transmitter.
interface phy_reset_transmitter_if;
    logic [7:0] TRANSMIT;
    logic       tx_start;
    logic       abort;
    logic       tx_en;
    logic       tx_data;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_fail;

    modport master (
        output TRANSMIT, tx_start, abort,
        input  tx_en, tx_data, tx_busy, tx_done, tx_fail
    );

    modport slave (
        input  TRANSMIT, tx_start, abort,
        output tx_en, tx_data, tx_busy, tx_done, tx_fail
    );
endinterface

// File: rtl/phy_reset_transmitter.sv
// USB PD Hard/Cable Reset PHY transmitter: preamble + 4 K-code ordered set.
// Define BMC_EN for BMC line coding plus trailing low; default build is NRZ.
module phy_reset_transmitter #(
    parameter int HALF_BIT_DIV  = 10,
    parameter int PREAMBLE_BITS = 64
) (
    input  logic                  CLK,
    input  logic                  reset,
    phy_reset_transmitter_if.slave bus
);
    localparam int HW = (HALF_BIT_DIV > 1) ? $clog2(HALF_BIT_DIV) : 1;

    localparam logic [4:0] RST_1  = 5'b00111;
    localparam logic [4:0] RST_2  = 5'b11001;
    localparam logic [4:0] SYNC_1 = 5'b11000;
    localparam logic [4:0] SYNC_3 = 5'b00110;

    localparam logic [2:0] TYPE_HARD  = 3'b101;
    localparam logic [2:0] TYPE_CABLE = 3'b110;

    typedef enum logic [2:0] {
        IDLE, PREAMBLE, ORDSET, TRAIL, DONE, FAIL
    } state_t;

`ifdef BMC_EN
    localparam state_t POST_OS = TRAIL;
`else
    localparam state_t POST_OS = DONE;
`endif

    state_t        state_q, state_d;
    logic [HW-1:0] half_q;
    logic          phase_q;
    logic [6:0]    bit_q;
    logic [2:0]    type_q;

    logic          half_end, bit_end;
    logic          pre_last, os_last;
    logic          in_bits, cur_bit, valid;
    logic [19:0]   os_vec;
    logic [4:0]    unused_transmit;

    assign unused_transmit = bus.TRANSMIT[7:3];

    assign half_end = (half_q == HW'(HALF_BIT_DIV - 1));
    assign bit_end  = phase_q & half_end;
    assign pre_last = (bit_q == 7'(PREAMBLE_BITS - 1));
    assign os_last  = (bit_q == 7'd19);
    assign valid    = (bus.TRANSMIT[2:0] == TYPE_HARD) ||
                      (bus.TRANSMIT[2:0] == TYPE_CABLE);
    assign in_bits  = (state_q == PREAMBLE) || (state_q == ORDSET);

    // First K-code sits in the low bits so bit_q indexes LSB-first order.
    assign os_vec = (type_q == TYPE_CABLE) ?
                    {SYNC_3, RST_1, SYNC_1, RST_1} :
                    {RST_2, RST_1, RST_1, RST_1};

    assign cur_bit = (state_q == PREAMBLE) ? bit_q[0] : os_vec[bit_q[4:0]];

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.tx_start) state_d = valid ? PREAMBLE : FAIL;
            end
            PREAMBLE: begin
                if (bus.abort)                state_d = FAIL;
                else if (bit_end && pre_last) state_d = ORDSET;
            end
            ORDSET: begin
                if (bus.abort)               state_d = FAIL;
                else if (bit_end && os_last) state_d = POST_OS;
            end
            TRAIL: begin
                if (bus.abort)    state_d = FAIL;
                else if (half_end) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            FAIL:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            type_q <= '0;
        end else if (state_q == IDLE && bus.tx_start) begin
            type_q <= bus.TRANSMIT[2:0];
        end
    end

    // Timing restarts from zero on every state change.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            half_q  <= '0;
            phase_q <= 1'b0;
            bit_q   <= '0;
        end else if (state_d != state_q || state_q == IDLE) begin
            half_q  <= '0;
            phase_q <= 1'b0;
            bit_q   <= '0;
        end else if (half_end) begin
            half_q  <= '0;
            phase_q <= ~phase_q;
            if (phase_q) bit_q <= bit_q + 7'd1;
        end else begin
            half_q  <= half_q + HW'(1);
        end
    end

`ifdef BMC_EN
    logic lvl_q;

    // Line level at the end of the previous bit.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset)         lvl_q <= 1'b0;
        else if (!in_bits) lvl_q <= 1'b0;
        else if (bit_end)  lvl_q <= ~lvl_q ^ cur_bit;
    end

    assign bus.tx_data = in_bits & (phase_q ? (~lvl_q ^ cur_bit) : ~lvl_q);
`else
    assign bus.tx_data = in_bits & cur_bit;
`endif

    assign bus.tx_en   = in_bits | (state_q == TRAIL);
    assign bus.tx_busy = (state_q != IDLE);
    assign bus.tx_done = (state_q == DONE);
    assign bus.tx_fail = (state_q == FAIL);
endmodule

// File: tb/tb_phy_reset_transmitter.sv
// Scoreboard bench for phy_reset_transmitter.
// Expected line levels and end events are queued at stimulus time.
module tb_phy_reset_transmitter;
    localparam int H  = 2;
    localparam int PB = 64;
`ifdef BMC_EN
    localparam int FRAME = (PB + 20) * 2 * H + H;
`else
    localparam int FRAME = (PB + 20) * 2 * H;
`endif

    localparam logic [4:0] RST_1  = 5'b00111;
    localparam logic [4:0] RST_2  = 5'b11001;
    localparam logic [4:0] SYNC_1 = 5'b11000;
    localparam logic [4:0] SYNC_3 = 5'b00110;

    typedef struct {
        int kind;
        int at;
    } evt_t;

    logic CLK   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   n_tests = 0;
    int   n_fails = 0;
    bit   chk_idle = 1'b0;
    int   mon_kind;
    evt_t mon_e;

    logic exp_q[$];
    evt_t evt_q[$];

    phy_reset_transmitter_if bus();

    phy_reset_transmitter #(
        .HALF_BIT_DIV (H),
        .PREAMBLE_BITS(PB)
    ) dut (
        .CLK  (CLK),
        .reset(reset),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    task automatic push_frame(input logic [2:0] t);
        logic [19:0] os;
        logic        b;
        logic        lvl;
        lvl = 1'b0;
        os  = (t == 3'b110) ? {SYNC_3, RST_1, SYNC_1, RST_1}
                            : {RST_2, RST_1, RST_1, RST_1};
        for (int i = 0; i < PB + 20; i++) begin
            b = (i < PB) ? i[0] : os[i - PB];
`ifdef BMC_EN
            for (int h = 0; h < H; h++) exp_q.push_back(~lvl);
            for (int h = 0; h < H; h++) exp_q.push_back(~lvl ^ b);
            lvl = ~lvl ^ b;
`else
            for (int h = 0; h < 2 * H; h++) exp_q.push_back(b);
`endif
        end
`ifdef BMC_EN
        for (int h = 0; h < H; h++) exp_q.push_back(1'b0);
`endif
    endtask

    task automatic start_frame(input logic [7:0] tr, input bit hold);
        int k;
        @(negedge CLK);
        #1;
        bus.TRANSMIT = tr;
        bus.tx_start = 1'b1;
        k = cyc + 1;
        if (tr[2:0] == 3'b101 || tr[2:0] == 3'b110) begin
            push_frame(tr[2:0]);
            evt_q.push_back('{1, k + FRAME});
        end else begin
            evt_q.push_back('{2, k});
        end
        @(negedge CLK);
        #1;
        if (!hold) bus.tx_start = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while (evt_q.size() != 0 && n < limit) begin
            @(negedge CLK);
            #1;
            n++;
        end
        if (evt_q.size() != 0) begin
            chk("timeout", evt_q.size(), 0);
            evt_q.delete();
            exp_q.delete();
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_en"},   bus.tx_en,   0);
        chk({tag, "_data"}, bus.tx_data, 0);
        chk({tag, "_busy"}, bus.tx_busy, 0);
        chk({tag, "_done"}, bus.tx_done, 0);
        chk({tag, "_fail"}, bus.tx_fail, 0);
    endtask

    always @(negedge CLK) begin
        if (!reset) begin
            if (chk_idle) begin
                chk("busy_idle", bus.tx_busy, 0);
                chk_idle = 1'b0;
            end
            if (bus.tx_en) begin
                if (exp_q.size() == 0) chk("en_unexp", bus.tx_en, 0);
                else chk("tx_data", bus.tx_data, exp_q.pop_front());
            end
            if (bus.tx_done || bus.tx_fail) begin
                mon_kind = int'(bus.tx_done) + 2 * int'(bus.tx_fail);
                if (evt_q.size() == 0) begin
                    chk("evt_unexp", mon_kind, 0);
                end else begin
                    mon_e = evt_q.pop_front();
                    chk("evt_kind", mon_kind, mon_e.kind);
                    chk("evt_cyc", cyc, mon_e.at);
                end
                chk("en_at_evt", bus.tx_en, 0);
                chk("busy_at_evt", bus.tx_busy, 1);
                if (mon_kind == 1) chk("frame_left", exp_q.size(), 0);
                exp_q.delete();
                chk_idle = 1'b1;
            end
        end
    end

    initial begin
        bus.TRANSMIT = 8'h00;
        bus.tx_start = 1'b0;
        bus.abort    = 1'b0;
        repeat (3) @(negedge CLK);
        chk_zero("reset");
        reset = 1'b0;

        // Hard Reset; a TRANSMIT change mid-frame must not matter
        start_frame(8'h05, 1'b0);
        repeat (20) @(negedge CLK);
        bus.TRANSMIT = 8'h06;
        wait_idle(FRAME + 20);

        start_frame(8'h06, 1'b0);
        wait_idle(FRAME + 20);

        start_frame(8'h03, 1'b0);
        wait_idle(10);

        // Abort 50 cycles into a Hard Reset frame
        start_frame(8'h05, 1'b0);
        repeat (50) @(negedge CLK);
        #1;
        evt_q.delete();
        evt_q.push_back('{2, cyc + 1});
        bus.abort = 1'b1;
        @(negedge CLK);
        #1;
        bus.abort = 1'b0;
        wait_idle(10);

        start_frame(8'h05, 1'b0);
        wait_idle(FRAME + 20);

        // tx_start held high, then async reset mid-ordered-set
        start_frame(8'h06, 1'b1);
        repeat (280) @(negedge CLK);
        #2;
        chk("pre_rst_en", bus.tx_en, 1);
        bus.tx_start = 1'b0;
        reset = 1'b1;
        #1;
        chk_zero("async_rst");
        exp_q.delete();
        evt_q.delete();
        chk_idle = 1'b0;
        repeat (2) @(negedge CLK);
        reset = 1'b0;
        repeat (20) @(negedge CLK);

        start_frame(8'hFD, 1'b0);
        wait_idle(FRAME + 20);
        repeat (3) @(negedge CLK);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end
endmodule
